// File: rtl/udma_stream_framer.sv
// -----------------------------------------------------------------------------
// udma_stream_framer
//   Frames raw peripheral beats for the uDMA filter stream input. Each accepted
//   beat is tagged with a stream ID plus SOT/EOT markers derived from the
//   programmed frame length, then queued in a small FIFO. The FIFO head drives
//   the valid/ready output stream.
//
//   Optional feature macro: UDMA_FRAMER_DROP_EN
//     defined   : input never backpressures; beats that arrive while the FIFO
//                 is full are discarded and counted on drop_cnt_o (saturating).
//                 The frame counter still advances, so framing stays aligned.
//     undefined : in_ready_o deasserts while full; drop_cnt_o is tied to 0.
//
// Ports
//   sys_clk_i, rstn_i        clock, async active-low reset
//   cfg_en_i                 enable beat acceptance
//   cfg_clr_i                sync flush of FIFO, frame counter and drop count
//   cfg_frame_len_i          beats per frame (0 and 1 both mean 1)
//   cfg_stream_id_i          stream ID tag
//   in_valid_i/in_data_i/in_datasize_i/in_ready_o   source beat handshake
//   str_valid_o/str_data_o/str_datasize_o/str_id_o/str_sot_o/str_eot_o/
//   str_ready_i              framed output stream
//   frame_done_o             pulse the cycle after an EOT beat is popped
//   drop_cnt_o               discarded-beat count
// -----------------------------------------------------------------------------
module udma_stream_framer #(
  parameter int DATA_WIDTH      = 32,
  parameter int STREAMID_WIDTH  = 8,
  parameter int FRAME_LEN_WIDTH = 16,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                       sys_clk_i,
  input  logic                       rstn_i,
  input  logic                       cfg_en_i,
  input  logic                       cfg_clr_i,
  input  logic [FRAME_LEN_WIDTH-1:0] cfg_frame_len_i,
  input  logic [STREAMID_WIDTH-1:0]  cfg_stream_id_i,
  input  logic                       in_valid_i,
  input  logic [DATA_WIDTH-1:0]      in_data_i,
  input  logic [1:0]                 in_datasize_i,
  output logic                       in_ready_o,
  output logic                       str_valid_o,
  output logic [DATA_WIDTH-1:0]      str_data_o,
  output logic [1:0]                 str_datasize_o,
  output logic [STREAMID_WIDTH-1:0]  str_id_o,
  output logic                       str_sot_o,
  output logic                       str_eot_o,
  input  logic                       str_ready_i,
  output logic                       frame_done_o,
  output logic [15:0]                drop_cnt_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]     data;
    logic [1:0]                size;
    logic [STREAMID_WIDTH-1:0] id;
    logic                      sot;
    logic                      eot;
  } entry_t;

  entry_t                     mem_q [FIFO_DEPTH];
  logic [PW-1:0]              wr_q, rd_q;
  logic [FRAME_LEN_WIDTH-1:0] bcnt_q, bcnt_d;
  logic [FRAME_LEN_WIDTH-1:0] len_q;
  logic [STREAMID_WIDTH-1:0]  id_q;
  logic                       fd_q;

  logic                       empty, full, accept, push, pop;
  logic [FRAME_LEN_WIDTH-1:0] cur_len, eff_len;
  logic [STREAMID_WIDTH-1:0]  cur_id;
  entry_t                     head, new_e;

  // Extra pointer bit separates full (MSBs differ) from empty (equal).
  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);

`ifdef UDMA_FRAMER_DROP_EN
  logic [15:0] drop_q;
  assign in_ready_o = cfg_en_i & ~cfg_clr_i;
  always_ff @(posedge sys_clk_i or negedge rstn_i) begin
    if (!rstn_i)                                 drop_q <= '0;
    else if (cfg_clr_i)                          drop_q <= '0;
    else if (accept && full && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
  end
  assign drop_cnt_o = drop_q;
`else
  assign in_ready_o = cfg_en_i & ~cfg_clr_i & ~full;
  assign drop_cnt_o = '0;
`endif

  assign accept = in_valid_i & in_ready_o;
  // A full FIFO never takes a push, even with a simultaneous pop.
  assign push   = accept & ~full;
  assign pop    = str_valid_o & str_ready_i & ~cfg_clr_i;

  // The first beat of a frame uses live config; later beats use the copy
  // captured with that first beat, so mid-frame writes wait for the next frame.
  assign cur_len = (bcnt_q == '0) ? cfg_frame_len_i : len_q;
  assign cur_id  = (bcnt_q == '0) ? cfg_stream_id_i : id_q;
  assign eff_len = (cur_len == '0) ? FRAME_LEN_WIDTH'(1) : cur_len;

  always_comb begin
    new_e      = '0;
    new_e.data = in_data_i;
    new_e.size = in_datasize_i;
    new_e.id   = cur_id;
    new_e.sot  = (bcnt_q == '0);
    new_e.eot  = (bcnt_q == eff_len - FRAME_LEN_WIDTH'(1));
    bcnt_d     = new_e.eot ? '0 : bcnt_q + FRAME_LEN_WIDTH'(1);
  end

  assign head           = mem_q[rd_q[AW-1:0]];
  assign str_valid_o    = ~empty;
  assign str_data_o     = head.data;
  assign str_datasize_o = head.size;
  assign str_id_o       = head.id;
  assign str_sot_o      = head.sot;
  assign str_eot_o      = head.eot;
  assign frame_done_o   = fd_q;

  always_ff @(posedge sys_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_q   <= '0;
      rd_q   <= '0;
      bcnt_q <= '0;
      len_q  <= '0;
      id_q   <= '0;
      fd_q   <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (cfg_clr_i) begin
      wr_q   <= '0;
      rd_q   <= '0;
      bcnt_q <= '0;
      fd_q   <= 1'b0;
    end else begin
      fd_q <= pop & head.eot;
      if (pop) rd_q <= rd_q + PW'(1);
      if (push) begin
        mem_q[wr_q[AW-1:0]] <= new_e;
        wr_q                <= wr_q + PW'(1);
      end
      // Dropped beats still advance the counter to keep frame alignment.
      if (accept) begin
        if (bcnt_q == '0) begin
          len_q <= cfg_frame_len_i;
          id_q  <= cfg_stream_id_i;
        end
        bcnt_q <= bcnt_d;
      end
    end
  end

endmodule

// File: tb/tb_udma_stream_framer.sv
module tb_udma_stream_framer;
  localparam int DEPTH = 4;
`ifdef UDMA_FRAMER_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        en = 1'b0, clr = 1'b0;
  logic [15:0] cfg_len = '0;
  logic [7:0]  cfg_id = '0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic [1:0]  in_size = '0;
  logic        in_ready;
  logic        str_valid, str_sot, str_eot, str_ready = 1'b0, frame_done;
  logic [31:0] str_data;
  logic [1:0]  str_size;
  logic [7:0]  str_id;
  logic [15:0] drop_cnt;

  udma_stream_framer dut (
    .sys_clk_i(clk), .rstn_i(rstn), .cfg_en_i(en), .cfg_clr_i(clr),
    .cfg_frame_len_i(cfg_len), .cfg_stream_id_i(cfg_id),
    .in_valid_i(in_valid), .in_data_i(in_data), .in_datasize_i(in_size),
    .in_ready_o(in_ready), .str_valid_o(str_valid), .str_data_o(str_data),
    .str_datasize_o(str_size), .str_id_o(str_id), .str_sot_o(str_sot),
    .str_eot_o(str_eot), .str_ready_i(str_ready), .frame_done_o(frame_done),
    .drop_cnt_o(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic [1:0]  s;
    logic [7:0]  id;
    bit          sot;
    bit          eot;
  } beat_t;

  // Reference model: queue of framed beats plus a frame position counter.
  beat_t q[$];
  beat_t plog[$];
  int    bcnt, sh_len, m_drop, fd_cnt;
  logic [7:0] sh_id;
  bit    m_fd, m_acc, m_rdy;
  int    n_vec, n_err;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    bcnt = 0; m_fd = 0; m_drop = 0; sh_len = 0; sh_id = '0;
  endtask

  // Compare process: outputs settled from the last edge, inputs for this cycle.
  task automatic check_outputs();
    m_rdy = en && !clr && (DROP || q.size() < DEPTH);
    chk("in_ready", 64'(in_ready), 64'(m_rdy));
    chk("str_valid", 64'(str_valid), 64'(q.size() > 0));
    if (q.size() > 0) begin
      chk("str_data", 64'(str_data), 64'(q[0].d));
      chk("str_size", 64'(str_size), 64'(q[0].s));
      chk("str_id",   64'(str_id),   64'(q[0].id));
      chk("str_sot",  64'(str_sot),  64'(q[0].sot));
      chk("str_eot",  64'(str_eot),  64'(q[0].eot));
    end
    chk("frame_done", 64'(frame_done), 64'(m_fd));
    chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
  endtask

  task automatic model_next();
    bit pop, accept;
    pop    = (q.size() > 0) && str_ready;
    accept = in_valid && m_rdy;
    m_acc  = accept;
    if (clr) begin
      q.delete(); bcnt = 0; m_fd = 0; m_drop = 0; m_acc = 0;
    end else begin
      m_fd = pop && q[0].eot;
      if (pop) begin
        plog.push_back(q[0]);
        if (q[0].eot) fd_cnt++;
      end
      if (accept) begin
        int    len;
        beat_t b;
        bit    was_full;
        was_full = (q.size() == DEPTH);
        if (bcnt == 0) begin sh_len = int'(cfg_len); sh_id = cfg_id; end
        len   = (sh_len == 0) ? 1 : sh_len;
        b.d   = in_data; b.s = in_size; b.id = sh_id;
        b.sot = (bcnt == 0);
        b.eot = (bcnt == len - 1);
        if (pop) void'(q.pop_front());
        if (!was_full) q.push_back(b);
        else if (m_drop < 65535) m_drop++;
        bcnt = b.eot ? 0 : bcnt + 1;
      end else if (pop) begin
        void'(q.pop_front());
      end
    end
  endtask

  task automatic step();
    #1;
    check_outputs();
    model_next();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rstn = 1'b0; en = 1'b0; clr = 1'b0; in_valid = 1'b0;
    #1;
    model_reset();
    chk("rst in_ready", 64'(in_ready), 64'd0);
    chk("rst str_valid", 64'(str_valid), 64'd0);
    chk("rst str_data", 64'(str_data), 64'd0);
    chk("rst str_size", 64'(str_size), 64'd0);
    chk("rst str_id", 64'(str_id), 64'd0);
    chk("rst sot_eot", 64'({str_sot, str_eot}), 64'd0);
    chk("rst frame_done", 64'(frame_done), 64'd0);
    chk("rst drop_cnt", 64'(drop_cnt), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic idle(int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  // Offer n beats back-to-back; optionally rewrite the frame length once
  // k beats have been accepted.
  task automatic send(int n, int base, int chg_at, int chg_len);
    int k, guard;
    k = 0; guard = 0;
    while (k < n && guard < 200) begin
      if (k == chg_at) cfg_len = 16'(chg_len);
      in_valid = 1'b1;
      in_data  = 32'(base + k);
      in_size  = 2'($urandom);
      step();
      if (m_acc) k++;
      guard++;
    end
    in_valid = 1'b0;
    if (k < n) begin
      n_vec++; n_err++;
      $display("FAIL send timeout: got %0d beats expected %0d", k, n);
    end
  endtask

  initial begin
    int k;
    n_vec = 0; n_err = 0; fd_cnt = 0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Frames of 4, back-to-back, no stall.
    en = 1; str_ready = 1; cfg_len = 4; cfg_id = 8'h5A;
    plog.delete(); fd_cnt = 0;
    send(8, 0, -1, 0);
    idle(4);
    chk("t1 count", 64'(plog.size()), 64'd8);
    for (int i = 0; i < plog.size(); i++) begin
      chk("t1 data", 64'(plog[i].d), 64'(i));
      chk("t1 sot", 64'(plog[i].sot), 64'(i % 4 == 0));
      chk("t1 eot", 64'(plog[i].eot), 64'(i % 4 == 3));
      chk("t1 id", 64'(plog[i].id), 64'h5A);
    end
    chk("t1 frame_done pulses", 64'(fd_cnt), 64'd2);

    // Length 0 and 1 both give single-beat frames.
    for (int l = 0; l < 2; l++) begin
      cfg_len = 16'(l); plog.delete();
      send(3, 50, -1, 0);
      idle(3);
      for (int i = 0; i < plog.size(); i++)
        chk("t2 single", 64'({plog[i].sot, plog[i].eot}), 64'd3);
      chk("t2 count", 64'(plog.size()), 64'd3);
    end

    // Stall with six beats offered into a four-deep FIFO.
    cfg_len = 4; str_ready = 0; plog.delete(); k = 0;
    for (int c = 0; c < 8; c++) begin
      in_valid = (k < 6);
      in_data  = 32'(100 + k);
      step();
      if (m_acc) k++;
    end
    chk("t3 accepts while stalled", 64'(k), DROP ? 64'd6 : 64'd4);
    str_ready = 1;
    send(6 - k, 100 + k, -1, 0);
    idle(6);
    chk("t3 drop_cnt", 64'(drop_cnt), DROP ? 64'd2 : 64'd0);
    chk("t3 count", 64'(plog.size()), DROP ? 64'd4 : 64'd6);
    for (int i = 0; i < plog.size(); i++)
      chk("t3 order", 64'(plog[i].d), 64'(100 + i));
    plog.delete();
    send(2, 106, -1, 0);
    idle(3);
    chk("t3 realign eot", 64'({plog[0].sot, plog[0].eot, plog[1].sot, plog[1].eot}), 64'b0001);

    // Mid-frame length write applies to the next frame.
    clr = 1; step(); clr = 0;
    cfg_len = 3; plog.delete();
    send(8, 200, 2, 5);
    idle(3);
    for (int i = 0; i < plog.size(); i++)
      chk("t4 eot", 64'(plog[i].eot), 64'(i == 2 || i == 7));

    // Clear after two beats of a four-beat frame.
    cfg_len = 4; str_ready = 0;
    send(2, 250, -1, 0);
    clr = 1; step(); clr = 0;
    #1 chk("t5 empty after clr", 64'(str_valid), 64'd0);
    str_ready = 1; plog.delete();
    send(1, 300, -1, 0);
    idle(2);
    chk("t5 sot after clr", 64'(plog[0].sot), 64'd1);

    // Enable low mid-frame.
    clr = 1; step(); clr = 0;
    plog.delete();
    send(2, 400, -1, 0);
    en = 0; in_valid = 1; in_data = 402;
    for (int i = 0; i < 10; i++) step();
    en = 1;
    send(2, 402, -1, 0);
    idle(3);
    chk("t6 count", 64'(plog.size()), 64'd4);
    for (int i = 0; i < plog.size(); i++)
      chk("t6 eot", 64'(plog[i].eot), 64'(i == 3));

    // Randomized traffic with one reset in the middle.
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) do_reset();
      en        = ($urandom_range(0, 9) != 0);
      clr       = ($urandom_range(0, 39) == 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      str_ready = ($urandom_range(0, 9) < 6);
      in_data   = $urandom;
      in_size   = 2'($urandom);
      if ($urandom_range(0, 9) == 0) cfg_len = 16'($urandom_range(0, 5));
      if ($urandom_range(0, 9) == 0) cfg_id = 8'($urandom);
      step();
    end
    clr = 0; in_valid = 0; str_ready = 1;
    idle(8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/udma_stream_framer.md
# udma_stream_framer

Stream framing stage directly upstream of the uDMA filter's stream input. It accepts raw beats from a peripheral source and tags each with a stream ID, start-of-frame and end-of-frame markers derived from a programmed frame length. It buffers beats in a small FIFO and presents them on the valid/ready stream interface the filter consumes (`stream_id`, `data`, `datasize`, `valid`, `sot`, `eot`, `ready`).

## Interface
- `DATA_WIDTH`, 32: width of data beats.
- `STREAMID_WIDTH`, 8: width of the stream ID tag; matches the filter ID width.
- `FRAME_LEN_WIDTH`, 16: width of the frame-length configuration and the beat counter.
- `FIFO_DEPTH`, 4: output FIFO entries; power of two, at least 2.
- `sys_clk_i` in 1: single clock.
- `rstn_i` in 1: asynchronous active-low reset.
- `cfg_en_i` in 1: enable beat acceptance.
- `cfg_clr_i` in 1: synchronous flush of FIFO and frame state.
- `cfg_frame_len_i` in FRAME_LEN_WIDTH: beats per frame.
- `cfg_stream_id_i` in STREAMID_WIDTH: ID attached to beats.
- `in_valid_i` in 1: source beat valid.
- `in_data_i` in DATA_WIDTH: source data.
- `in_datasize_i` in 2: source beat size code.
- `in_ready_o` out 1: beat accepted when high with `in_valid_i`.
- `str_valid_o` out 1: output beat valid.
- `str_data_o` out DATA_WIDTH: output data.
- `str_datasize_o` out 2: output size code.
- `str_id_o` out STREAMID_WIDTH: stream ID of the beat.
- `str_sot_o` out 1: first beat of frame.
- `str_eot_o` out 1: last beat of frame.
- `str_ready_i` in 1: downstream accepts the head beat.
- `frame_done_o` out 1: one-cycle pulse when an EOT beat is consumed downstream.
- `drop_cnt_o` out 16: dropped beat count.

## Operation
- Accept = `in_valid_i & in_ready_o`. Pop = `str_valid_o & str_ready_i`.
- Beat counter `bcnt` counts accepted beats within a frame.
- At `bcnt==0`, the block latches `cfg_frame_len_i` and `cfg_stream_id_i` into shadow registers. They hold for the whole frame, so mid-frame config writes take effect at the next frame.
- Effective length L = max(shadow_len, 1). Length 0 or 1 produces single-beat frames with SOT and EOT both set.
- Tags on each accepted beat:
  - `sot = (bcnt==0)`
  - `eot = (bcnt==L-1)`
  - `bcnt` wraps to 0 after the EOT beat and increments otherwise.
- The FIFO entry stores {data, datasize, id, sot, eot}. There is no bypass path.
- `cfg_en_i` low: no accepts. `bcnt`, the shadow registers and the FIFO hold. Queued beats keep draining, and framing resumes where it stopped.
- `cfg_clr_i` high: FIFO emptied, `bcnt` set to 0, `drop_cnt_o` set to 0. No accept occurs and `frame_done_o` is 0 that cycle. Clear has priority over push, pop and enable.
- `frame_done_o` is registered and pulses the cycle after a pop whose head beat has `eot=1`.

## Timing
- Reset values: `in_ready_o`=0, `str_valid_o`=0, `str_data_o`=0, `str_datasize_o`=0, `str_id_o`=0, `str_sot_o`=0, `str_eot_o`=0, `frame_done_o`=0, `drop_cnt_o`=0. Internally, `bcnt`=0 and the FIFO is empty.
- Latency: a beat accepted in cycle N is visible on `str_*` in cycle N+1.
- `in_ready_o` = `cfg_en_i & ~cfg_clr_i & ~full`, combinational from registered state.
- When full, `in_ready_o`=0 even if a pop occurs in the same cycle; no same-cycle pass-through.
- Push and pop in the same cycle with the FIFO neither empty nor full: occupancy is unchanged and order is preserved.
- `str_*` payload must stay stable while `str_valid_o=1` and `str_ready_i=0`.
- Pointers wrap modulo FIFO_DEPTH; a separate count/extra bit distinguishes full from empty.
- Asserting reset mid-frame discards all state; the first accepted beat after reset carries `sot=1`.

## Configuration
- Macro: `UDMA_FRAMER_DROP_EN`.
- Defined:
  - `in_ready_o` = `cfg_en_i & ~cfg_clr_i`, ignoring `full`.
  - A beat accepted while the FIFO is full is discarded, but `bcnt` still advances so frame alignment is kept.
  - `drop_cnt_o` increments by 1 per discarded beat and saturates at 16'hFFFF.
- Undefined: backpressure as described above, and `drop_cnt_o` is constant 0.

## Test plan
- L=4, ID=0x5A, 8 back-to-back beats 0..7, `str_ready_i`=1 → SOT on beats 0 and 4, EOT on beats 3 and 7, all IDs 0x5A, `frame_done_o` pulses twice, each output one cycle after its accept.
- L=0 → every beat has SOT=1 and EOT=1. L=1 gives the same result.
- `str_ready_i`=0, 6 beats offered with depth 4 → `in_ready_o` drops after 4 accepts. Release → beats 0..5 in order, payload stable while stalled. With `UDMA_FRAMER_DROP_EN`: beats 4 and 5 dropped, `drop_cnt_o`=2, next frame's SOT lands at the correct position.
- L=3, write L=5 after beat 1 → frame closes at beat 2 (EOT), the next frame uses 5 beats.
- 2 beats of an L=4 frame accepted, then `cfg_clr_i` pulse → FIFO empty, `str_valid_o`=0, next accepted beat has SOT=1.
- `cfg_en_i` low for 10 cycles mid-frame (after beat 1 of L=4) → no accepts. After resume, beats 2 and 3 complete the frame with EOT on beat 3.
